// File: rtl/vmicro16_apb_master.sv
// APB3 master bridge for the vmicro16 memory stage: one load/store request
// becomes one APB transfer, with the core stalled until PREADY or timeout.
module vmicro16_apb_master #(
  parameter int BUS_WIDTH = 16,
  parameter int TIMEOUT   = 255,
  parameter int TO_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 req,
  input  logic                 req_we,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [BUS_WIDTH-1:0] rdata,

  output logic [BUS_WIDTH-1:0] M_PADDR,
  output logic                 M_PWRITE,
  output logic                 M_PSELx,
  output logic                 M_PENABLE,
  output logic [BUS_WIDTH-1:0] M_PWDATA,
  input  logic [BUS_WIDTH-1:0] M_PRDATA,
  input  logic                 M_PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);
  localparam logic [TO_WIDTH-1:0] CNT_MAX  = '1;

  state_t               state_reg, state_next;
  logic [BUS_WIDTH-1:0] addr_reg;
  logic [BUS_WIDTH-1:0] wdata_reg;
  logic [BUS_WIDTH-1:0] rdata_reg;
  logic                 we_reg;
  logic                 err_reg;
  logic [TO_WIDTH-1:0]  cnt_reg;
  logic                 timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TO_LIMIT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (M_PREADY || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            we_reg    <= req_we;
            err_reg   <= 1'b0;
          end
        end
        ACCESS: begin
          // PREADY takes priority over a timeout landing in the same cycle
          if (M_PREADY) begin
            err_reg <= 1'b0;
            if (!we_reg) rdata_reg <= M_PRDATA;
          end else begin
            if (timeout_hit)        err_reg <= 1'b1;
            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE:    cnt_reg <= '0;
        default: ;
      endcase
    end
  end

  // Bus controls decode straight from state so reset releases them at once
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign M_PSELx   = (state_reg == SETUP) || (state_reg == ACCESS);
  assign M_PENABLE = (state_reg == ACCESS);
  assign M_PADDR   = addr_reg;
  assign M_PWRITE  = we_reg;
  assign M_PWDATA  = wdata_reg;
  assign err       = err_reg;
  assign rdata     = rdata_reg;

endmodule

// File: tb/tb_vmicro16_apb_master.sv
// Scoreboard bench for vmicro16_apb_master: a driver issues requests and
// queues the expected outcome, a monitor checks the bus and each done pulse.
module tb_vmicro16_apb_master;
  localparam int BW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0, req_we = 1'b0;
  logic [BW-1:0] req_addr = '0, req_wdata = '0;
  logic          busy, done, err;
  logic [BW-1:0] rdata, M_PADDR, M_PWDATA;
  logic          M_PWRITE, M_PSELx, M_PENABLE;
  logic [BW-1:0] M_PRDATA = '0;
  logic          M_PREADY = 1'b0;

  vmicro16_apb_master #(.BUS_WIDTH(BW), .TIMEOUT(TO), .TO_WIDTH(4)) dut (
    .clk(clk), .reset(rst),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
    .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA),
    .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [BW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    logic          err;
    int            done_cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            cur_waits = 0;
  logic [BW-1:0] cur_prdata = '0;
  logic [BW-1:0] rdata_model = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Slave: PREADY rises on ACCESS cycle number cur_waits (0-based)
  int acc_idx = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (M_PENABLE) begin
        M_PREADY = (acc_idx == cur_waits);
        M_PRDATA = M_PREADY ? cur_prdata : BW'($urandom);
        acc_idx++;
      end else begin
        M_PREADY = 1'($urandom);
        M_PRDATA = BW'($urandom);
        acc_idx  = 0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (M_PSELx) begin
        if (exp_q.size() == 0) chk("psel_without_request", 32'(M_PSELx), 32'h0);
        else begin
          chk("paddr", 32'(M_PADDR), 32'(exp_q[0].addr));
          chk("pwrite", 32'(M_PWRITE), 32'(exp_q[0].we));
          if (exp_q[0].we) chk("pwdata", 32'(M_PWDATA), 32'(exp_q[0].wdata));
        end
      end
      if (M_PENABLE && !M_PSELx) chk("penable_without_psel", 32'(M_PSELx), 32'h1);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'h0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("err", 32'(err), 32'(e.err));
          chk("rdata", 32'(rdata), 32'(e.rdata));
          chk("busy_in_done", 32'(busy), 32'h1);
          chk("psel_in_done", 32'(M_PSELx), 32'h0);
        end
      end
    end
  end

  // Issue one request in the current IDLE cycle and wait until IDLE again.
  task automatic run_txn(input logic we, input logic [BW-1:0] addr, input logic [BW-1:0] wdata,
                         input logic [BW-1:0] prdata, input int waits, input bit hold);
    exp_t e;
    int n;
    cur_waits  = waits;
    cur_prdata = prdata;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.err   = (waits > TO);
    if (!we && !e.err) rdata_model = prdata;
    e.rdata    = rdata_model;
    e.done_cyc = cyc + 3 + ((waits < TO) ? waits : TO);
    exp_q.push_back(e);
    req = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy && hold) begin
        req_we = 1'($urandom); req_addr = BW'($urandom); req_wdata = BW'($urandom);
      end else req = 1'b0;
    end while (busy && n < 100);
    if (n >= 100) chk("transfer_timeout_bound", 32'(busy), 32'h0);
  endtask

  initial begin
    int n;
    #3;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_psel", 32'(M_PSELx), 32'h0);
    chk("rst_penable", 32'(M_PENABLE), 32'h0);
    chk("rst_paddr", 32'(M_PADDR), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_txn(1'b0, 16'h0088, 16'h0000, 16'hBEEF, 0, 1'b0);
    run_txn(1'b1, 16'h00A0, 16'h00FF, 16'h1234, 3, 1'b0);
    run_txn(1'b0, 16'h0010, 16'h0000, 16'h5555, 20, 1'b0);
    run_txn(1'b0, 16'h0012, 16'h0000, 16'hC0DE, TO, 1'b0);
    chk("simultaneous_rdata", 32'(rdata), 32'hC0DE);

    // Reset in the middle of ACCESS
    run_txn_start: begin
      exp_t e;
      cur_waits = 15; cur_prdata = 16'hDEAD;
      e.we = 1'b0; e.addr = 16'h0077; e.wdata = '0; e.rdata = '0; e.err = 1'b0; e.done_cyc = 0;
      exp_q.push_back(e);
      req = 1'b1; req_we = 1'b0; req_addr = 16'h0077; req_wdata = '0;
      @(posedge clk); #1; req = 1'b0;
      n = 0;
      while (!M_PENABLE && n < 10) begin @(posedge clk); #1; n++; end
      chk("reached_access", 32'(M_PENABLE), 32'h1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst_psel", 32'(M_PSELx), 32'h0);
      chk("midrst_penable", 32'(M_PENABLE), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_done", 32'(done), 32'h0);
      chk("midrst_rdata", 32'(rdata), 32'h0);
      exp_q.delete();
      rdata_model = '0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
    end

    run_txn(1'b0, 16'h0099, 16'h0000, 16'hA5A5, 1, 1'b0);

    // Back-to-back with req held high while busy
    for (int i = 0; i < 6; i++)
      run_txn(1'($urandom), BW'($urandom), BW'($urandom), BW'($urandom), $urandom_range(0, 2), 1'b1);
    req = 1'b0;

    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom), BW'($urandom), BW'($urandom), BW'($urandom),
              $urandom_range(0, 7), 1'($urandom));
      req = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
